// File: rtl/alu_cmd_responder.sv
// rtl/alu_cmd_responder.sv - registered command/response wrapper around the 6-bit ALU op set
module alu_cmd_responder #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [W-1:0] cmd_x,
    input  logic [W-1:0] cmd_y,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_z,
    output logic [W:0]   rsp_zNoRing,
    output logic         rsp_BAF,
    output logic         rsp_ZF,
    output logic         rsp_IOF,
    output logic [15:0]  op_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_NEG     = 4'b0000;
    localparam logic [3:0] OP_UNUSED  = 4'b0001;
    localparam logic [3:0] OP_EQ      = 4'b0010;
    localparam logic [3:0] OP_DIFF    = 4'b0011;
    localparam logic [3:0] OP_MORE    = 4'b0100;
    localparam logic [3:0] OP_MORE_EQ = 4'b0101;
    localparam logic [3:0] OP_LESS    = 4'b0110;
    localparam logic [3:0] OP_LESS_EQ = 4'b0111;
    localparam logic [3:0] OP_INC     = 4'b1000;
    localparam logic [3:0] OP_DEC     = 4'b1001;
    localparam logic [3:0] OP_ADD     = 4'b1010;
    localparam logic [3:0] OP_SUB     = 4'b1011;
    localparam logic [3:0] OP_NAND    = 4'b1100;
    localparam logic [3:0] OP_XOR     = 4'b1101;
    localparam logic [3:0] OP_AND     = 4'b1110;
    localparam logic [3:0] OP_OR      = 4'b1111;

    localparam logic [W:0]   ONE_EXT = {{W{1'b0}}, 1'b1};
    localparam logic [W-1:0] TRUE_Z  = {{(W-1){1'b0}}, 1'b1};

    state_t       r_state;
    state_t       w_state_next;
    logic         w_latch;
    logic         w_rsp_fire;

    logic [3:0]   r_op;
    logic [W-1:0] r_x;
    logic [W-1:0] r_y;

    logic [W:0]   w_xs;
    logic [W:0]   w_ys;
    logic [W-1:0] w_z;
    logic [W:0]   w_zn;
    logic         w_baf;
    logic         w_iof;
    logic         w_arith;

    logic [W-1:0] r_z;
    logic [W:0]   r_zn;
    logic         r_baf;
    logic         r_zf;
    logic         r_iof;
    logic [15:0]  r_count;

    // State register; reset abandons any latched command or pending response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake decode; cmd_ready depends only on state and rsp_ready
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        w_latch      = 1'b0;
        w_rsp_fire   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_latch      = 1'b1;
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_rsp_fire = 1'b1;
                    cmd_ready  = 1'b1;
                    if (cmd_valid) begin
                        w_latch      = 1'b1;
                        w_state_next = ST_EXEC;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Command capture on every accepted cmd handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op <= 4'd0;
            r_x  <= '0;
            r_y  <= '0;
        end else if (w_latch) begin
            r_op <= cmd_op;
            r_x  <= cmd_x;
            r_y  <= cmd_y;
        end
    end

    assign w_xs = {r_x[W-1], r_x};
    assign w_ys = {r_y[W-1], r_y};

    // ALU datapath from the latched command; arithmetic runs one bit wider than W
    always_comb begin
        w_z     = '0;
        w_zn    = '0;
        w_baf   = 1'b0;
        w_arith = 1'b0;
        case (r_op)
            OP_NEG: begin
                w_zn    = (~w_xs) + ONE_EXT;
                w_arith = 1'b1;
            end
            OP_UNUSED: begin
                w_baf = 1'b1;
            end
            OP_EQ:      w_z = (r_x == r_y) ? TRUE_Z : '0;
            OP_DIFF:    w_z = (r_x != r_y) ? TRUE_Z : '0;
            OP_MORE:    w_z = ($signed(r_x) >  $signed(r_y)) ? TRUE_Z : '0;
            OP_MORE_EQ: w_z = ($signed(r_x) >= $signed(r_y)) ? TRUE_Z : '0;
            OP_LESS:    w_z = ($signed(r_x) <  $signed(r_y)) ? TRUE_Z : '0;
            OP_LESS_EQ: w_z = ($signed(r_x) <= $signed(r_y)) ? TRUE_Z : '0;
            OP_INC: begin
                w_zn    = w_xs + ONE_EXT;
                w_arith = 1'b1;
            end
            OP_DEC: begin
                w_zn    = w_xs - ONE_EXT;
                w_arith = 1'b1;
            end
            OP_ADD: begin
                w_zn    = w_xs + w_ys;
                w_arith = 1'b1;
            end
            OP_SUB: begin
                w_zn    = w_xs - w_ys;
                w_arith = 1'b1;
            end
            OP_NAND:    w_z = ~(r_x & r_y);
            OP_XOR:     w_z = r_x ^ r_y;
            OP_AND:     w_z = r_x & r_y;
            OP_OR:      w_z = r_x | r_y;
            default: begin
                w_z = '0;
            end
        endcase
        // Arithmetic ops wrap the wide result; the rest widen the narrow one
        if (w_arith) begin
            w_z = w_zn[W-1:0];
        end else begin
            w_zn = {w_z[W-1], w_z};
        end
    end

    assign w_iof = w_arith & (w_zn[W] != w_zn[W-1]);

    // Response fields load only in EXEC so they stay frozen while RESP waits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_z   <= '0;
            r_zn  <= '0;
            r_baf <= 1'b0;
            r_zf  <= 1'b0;
            r_iof <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_z   <= w_z;
            r_zn  <= w_zn;
            r_baf <= w_baf;
            r_zf  <= (w_z == '0);
            r_iof <= w_iof;
        end
    end

    // Delivered-response counter, bumped once per completed rsp handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 16'd0;
        end else if (w_rsp_fire) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign rsp_z       = r_z;
    assign rsp_zNoRing = r_zn;
    assign rsp_BAF     = r_baf;
    assign rsp_ZF      = r_zf;
    assign rsp_IOF     = r_iof;
    assign op_count    = r_count;

endmodule

// File: tb/tb_alu_cmd_responder.sv
// tb/tb_alu_cmd_responder.sv - self-checking bench for alu_cmd_responder
module tb_alu_cmd_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = 4'd0;
    logic [5:0]  cmd_x = 6'd0;
    logic [5:0]  cmd_y = 6'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [5:0]  rsp_z;
    logic [6:0]  rsp_zNoRing;
    logic        rsp_BAF;
    logic        rsp_ZF;
    logic        rsp_IOF;
    logic [15:0] op_count;

    alu_cmd_responder #(.W(6)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_z(rsp_z), .rsp_zNoRing(rsp_zNoRing),
        .rsp_BAF(rsp_BAF), .rsp_ZF(rsp_ZF), .rsp_IOF(rsp_IOF),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] op;
        logic [5:0] x;
        logic [5:0] y;
        logic [5:0] z;
        logic [6:0] zn;
        logic       baf;
        logic       zf;
        logic       iof;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic [5:0] z, input logic [6:0] zn,
                           input logic baf, input logic zf, input logic iof);
        chk({tag, ".z"},   32'(rsp_z),       32'(z));
        chk({tag, ".zn"},  32'(rsp_zNoRing), 32'(zn));
        chk({tag, ".BAF"}, 32'(rsp_BAF),     32'(baf));
        chk({tag, ".ZF"},  32'(rsp_ZF),      32'(zf));
        chk({tag, ".IOF"}, 32'(rsp_IOF),     32'(iof));
    endtask

    // Reference: signed integer arithmetic, overflow judged by the 6-bit range
    function automatic logic [15:0] model(input logic [3:0] op, input logic [5:0] x, input logic [5:0] y);
        int a;
        int b;
        int r;
        bit arith;
        logic [5:0] z;
        logic [6:0] zn;
        logic baf;
        logic iof;
        a = $signed(x);
        b = $signed(y);
        r = 0;
        arith = 1'b0;
        z = 6'd0;
        baf = 1'b0;
        case (op)
            4'd0:  begin r = -a;    arith = 1'b1; end
            4'd1:  baf = 1'b1;
            4'd2:  z = (a == b) ? 6'd1 : 6'd0;
            4'd3:  z = (a != b) ? 6'd1 : 6'd0;
            4'd4:  z = (a >  b) ? 6'd1 : 6'd0;
            4'd5:  z = (a >= b) ? 6'd1 : 6'd0;
            4'd6:  z = (a <  b) ? 6'd1 : 6'd0;
            4'd7:  z = (a <= b) ? 6'd1 : 6'd0;
            4'd8:  begin r = a + 1; arith = 1'b1; end
            4'd9:  begin r = a - 1; arith = 1'b1; end
            4'd10: begin r = a + b; arith = 1'b1; end
            4'd11: begin r = a - b; arith = 1'b1; end
            4'd12: z = ~(x & y);
            4'd13: z = x ^ y;
            4'd14: z = x & y;
            default: z = x | y;
        endcase
        if (arith) begin
            zn  = r[6:0];
            z   = r[5:0];
            iof = (r > 31) || (r < -32);
        end else begin
            zn  = {z[5], z};
            iof = 1'b0;
        end
        return {z, zn, baf, (z == 6'd0), iof};
    endfunction

    // Present one command from IDLE and check latency of its response
    task automatic issue(input logic [3:0] op, input logic [5:0] x, input logic [5:0] y);
        @(negedge clk);
        chk("issue.cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = x;
        cmd_y     = y;
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("issue.rsp_valid_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("issue.rsp_valid", 32'(rsp_valid), 32'd1);
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    logic [15:0] c;
    logic [15:0] e;
    logic [5:0]  snap_z;
    logic [6:0]  snap_zn;
    logic [15:0] q[$];
    int sent;
    int got;
    int last_cyc;
    bit adv;

    initial begin
        vt[0]  = '{4'hA, 6'h1F, 6'h01, 6'h20, 7'h20, 1'b0, 1'b0, 1'b1};
        vt[1]  = '{4'h5, 6'h15, 6'h35, 6'h01, 7'h01, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{4'h6, 6'h15, 6'h35, 6'h00, 7'h00, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{4'h1, 6'h2A, 6'h11, 6'h00, 7'h00, 1'b1, 1'b1, 1'b0};
        vt[4]  = '{4'h0, 6'h20, 6'h00, 6'h20, 7'h20, 1'b0, 1'b0, 1'b1};
        vt[5]  = '{4'hB, 6'h20, 6'h01, 6'h1F, 7'h5F, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{4'h8, 6'h1F, 6'h00, 6'h20, 7'h20, 1'b0, 1'b0, 1'b1};
        vt[7]  = '{4'h9, 6'h01, 6'h00, 6'h00, 7'h00, 1'b0, 1'b1, 1'b0};
        vt[8]  = '{4'hC, 6'h3F, 6'h0F, 6'h30, 7'h70, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{4'hD, 6'h2A, 6'h15, 6'h3F, 7'h7F, 1'b0, 1'b0, 1'b0};
        vt[10] = '{4'hE, 6'h2A, 6'h0F, 6'h0A, 7'h0A, 1'b0, 1'b0, 1'b0};
        vt[11] = '{4'hF, 6'h20, 6'h01, 6'h21, 7'h61, 1'b0, 1'b0, 1'b0};
        vt[12] = '{4'h2, 6'h05, 6'h05, 6'h01, 7'h01, 1'b0, 1'b0, 1'b0};
        vt[13] = '{4'h3, 6'h05, 6'h05, 6'h00, 7'h00, 1'b0, 1'b1, 1'b0};
        vt[14] = '{4'h4, 6'h3F, 6'h01, 6'h00, 7'h00, 1'b0, 1'b1, 1'b0};
        vt[15] = '{4'h7, 6'h3F, 6'h3F, 6'h01, 7'h01, 1'b0, 1'b0, 1'b0};

        // Reset for two edges, then check the idle state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset.op_count",  32'(op_count),  32'd0);
        chk_rsp("reset", 6'h00, 7'h00, 1'b0, 1'b0, 1'b0);

        // Directed vectors, one full transaction each
        for (int i = 0; i < 16; i++) begin
            issue(vt[i].op, vt[i].x, vt[i].y);
            chk_rsp($sformatf("vec%0d", i), vt[i].z, vt[i].zn, vt[i].baf, vt[i].zf, vt[i].iof);
            c = op_count;
            release_rsp();
            chk("vec.op_count", 32'(op_count), 32'(c + 16'd1));
        end

        // Backpressure with a waiting command, then simultaneous handshakes
        issue(4'hA, 6'h03, 6'h04);
        snap_z  = rsp_z;
        snap_zn = rsp_zNoRing;
        c = op_count;
        chk("bp.first_z", 32'(snap_z), 32'h07);
        cmd_valid = 1'b1;
        cmd_op    = 4'hB;
        cmd_x     = 6'h05;
        cmd_y     = 6'h09;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp.rsp_valid", 32'(rsp_valid),   32'd1);
            chk("bp.cmd_ready", 32'(cmd_ready),   32'd0);
            chk("bp.z_stable",  32'(rsp_z),       32'(snap_z));
            chk("bp.zn_stable", 32'(rsp_zNoRing), 32'(snap_zn));
            chk("bp.op_count",  32'(op_count),    32'(c));
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp.cmd_ready_resp", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("bp.op_count_inc", 32'(op_count), 32'(c + 16'd1));
        chk("bp.exec_no_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("bp.next_valid", 32'(rsp_valid), 32'd1);
        chk_rsp("bp.next", 6'h3C, 7'h7C, 1'b0, 1'b0, 1'b0);
        release_rsp();

        // Reset while in EXEC abandons the command
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'hA;
        cmd_x     = 6'h01;
        cmd_y     = 6'h01;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstexec.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstexec.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rstexec.op_count",  32'(op_count),  32'd0);
        repeat (3) @(negedge clk);
        chk("rstexec.no_rsp", 32'(rsp_valid), 32'd0);

        // Streaming: random commands, rsp_ready held high
        sent = 0;
        got = 0;
        last_cyc = 0;
        adv = 1'b0;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 4'($urandom_range(0, 15));
        cmd_x     = 6'($urandom_range(0, 63));
        cmd_y     = 6'($urandom_range(0, 63));
        for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
            if (adv) begin
                adv = 1'b0;
                if (sent < 16) begin
                    cmd_op = 4'($urandom_range(0, 15));
                    cmd_x  = 6'($urandom_range(0, 63));
                    cmd_y  = 6'($urandom_range(0, 63));
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("stream.unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk_rsp($sformatf("stream%0d", got), e[15:10], e[9:3], e[2], e[1], e[0]);
                    if (got > 0) chk("stream.spacing", 32'(cyc - last_cyc), 32'd2);
                end
                last_cyc = cyc;
                got++;
            end
            if (cmd_valid && cmd_ready) begin
                q.push_back(model(cmd_op, cmd_x, cmd_y));
                sent++;
                adv = 1'b1;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        chk("stream.count",    32'(got),      32'd16);
        chk("stream.op_count", 32'(op_count), 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
